ex_stage: RTL and testbench

- Execute stage of the 5-stage pipeline; consumes the operand-fetch outputs: PC, IR, 22-bit control bus, Operand_A, Operand_B, Operand_2 and branchTarget.
- Performs ALU ops, maintains the E/GT flags, and resolves branches, calls and returns.
- Registers results into the EX/MA latch.
- Div/mod run on an iterative multi-cycle divider; EX stalls the upstream stages while it is busy.

---
 rtl/ex_stage.sv | 261 ++++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, E/GT flags, branch/call/return resolution,
// an iterative signed divider for div/mod, and the EX/MA pipeline latch.
module ex_stage #(
    parameter int XLEN               = 32,
    parameter int CTRL_W             = 22,
    parameter int DIV_BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   in_PC,
    input  logic [XLEN-1:0]   in_IR,
    input  logic [CTRL_W-1:0] in_controlBus,
    input  logic [XLEN-1:0]   Operand_A,
    input  logic [XLEN-1:0]   Operand_B,
    input  logic [XLEN-1:0]   Operand_2,
    input  logic [XLEN-1:0]   branchTarget,
    output logic              ex_stall,
    output logic              isBranchTaken,
    output logic [XLEN-1:0]   branchPC,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_PC,
    output logic [XLEN-1:0]   out_IR,
    output logic [XLEN-1:0]   aluResult,
    output logic [XLEN-1:0]   out_Operand_2,
    output logic [CTRL_W-1:0] out_controlBus,
    output logic              flag_E,
    output logic              flag_GT
);

    // Control bus bit positions.
    localparam int C_ST   = 0;
    localparam int C_LD   = 1;
    localparam int C_BEQ  = 2;
    localparam int C_BGT  = 3;
    localparam int C_RET  = 4;
    localparam int C_UBR  = 7;
    localparam int C_CALL = 8;
    localparam int C_ADD  = 9;
    localparam int C_SUB  = 10;
    localparam int C_CMP  = 11;
    localparam int C_MUL  = 12;
    localparam int C_DIV  = 13;
    localparam int C_MOD  = 14;
    localparam int C_LSL  = 15;
    localparam int C_LSR  = 16;
    localparam int C_ASR  = 17;
    localparam int C_OR   = 18;
    localparam int C_AND  = 19;
    localparam int C_NOT  = 20;
    localparam int C_MOV  = 21;

    localparam int SH_W  = $clog2(XLEN);
    localparam int STEPS = XLEN / DIV_BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              div_start;
    logic [CNT_W-1:0]  cnt;

    // Divider working registers and the captured instruction context.
    logic [XLEN-1:0]   quo_r;
    logic [XLEN:0]     rem_r;
    logic [XLEN-1:0]   dvs_r;
    logic [XLEN-1:0]   dvd_r;
    logic              neg_q;
    logic              neg_r;
    logic              dz_r;
    logic              mod_r;
    logic [XLEN-1:0]   cap_pc;
    logic [XLEN-1:0]   cap_ir;
    logic [XLEN-1:0]   cap_op2;
    logic [CTRL_W-1:0] cap_ctrl;

    logic [XLEN-1:0]   step_quo;
    logic [XLEN:0]     step_rem;
    logic [XLEN-1:0]   q_fin;
    logic [XLEN-1:0]   r_fin;
    logic [XLEN-1:0]   div_res;
    logic [XLEN-1:0]   alu_res;
    logic              is_divmod;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? -v : v;
    endfunction

    assign is_divmod = in_controlBus[C_DIV] | in_controlBus[C_MOD];

    // Divider FSM next-state and stall generation.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        ex_stall   = 1'b0;
        div_start  = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid && is_divmod) begin
                    ex_stall   = 1'b1;
                    div_start  = 1'b1;
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                ex_stall = 1'b1;
                if (cnt == LAST_STEP) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM state and iteration counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (div_start) begin
                cnt <= '0;
            end else if (state == S_BUSY) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // One divider cycle: retire DIV_BITS_PER_CYCLE quotient bits by restoring subtraction.
    always_comb begin
        step_quo = quo_r;
        step_rem = rem_r;
        for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
            // NOTE: blocking assignments here chain the per-bit steps within one cycle.
            step_rem = {step_rem[XLEN-1:0], step_quo[XLEN-1]};
            step_quo = {step_quo[XLEN-2:0], 1'b0};
            if (step_rem >= {1'b0, dvs_r}) begin
                step_rem    = step_rem - {1'b0, dvs_r};
                step_quo[0] = 1'b1;
            end
        end
    end

    // Divider datapath: load magnitudes on start, iterate while busy.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are not reset; they are always loaded before being read.
        if (div_start) begin
            quo_r    <= mag(Operand_A);
            rem_r    <= '0;
            dvs_r    <= mag(Operand_B);
            dvd_r    <= Operand_A;
            neg_q    <= Operand_A[XLEN-1] ^ Operand_B[XLEN-1];
            neg_r    <= Operand_A[XLEN-1];
            dz_r     <= (Operand_B == '0);
            mod_r    <= in_controlBus[C_MOD];
            cap_pc   <= in_PC;
            cap_ir   <= in_IR;
            cap_op2  <= Operand_2;
            cap_ctrl <= in_controlBus;
        end else if (state == S_BUSY) begin
            quo_r <= step_quo;
            rem_r <= step_rem;
        end
    end

    // Sign correction and divide-by-zero override of the final divider result.
    always_comb begin
        q_fin = neg_q ? -quo_r : quo_r;
        r_fin = neg_r ? -rem_r[XLEN-1:0] : rem_r[XLEN-1:0];
        if (dz_r) begin
            q_fin = '1;
            r_fin = dvd_r;
        end
        div_res = mod_r ? r_fin : q_fin;
    end

    // Single-cycle ALU result selection.
    always_comb begin
        alu_res = '0;
        if (in_controlBus[C_LD] || in_controlBus[C_ST]) alu_res = Operand_A + Operand_B;
        else if (in_controlBus[C_CALL]) alu_res = in_PC + XLEN'(4);
        else if (in_controlBus[C_ADD])  alu_res = Operand_A + Operand_B;
        else if (in_controlBus[C_SUB])  alu_res = Operand_A - Operand_B;
        else if (in_controlBus[C_MUL])  alu_res = $signed(Operand_A) * $signed(Operand_B);
        else if (in_controlBus[C_LSL])  alu_res = Operand_A << Operand_B[SH_W-1:0];
        else if (in_controlBus[C_LSR])  alu_res = Operand_A >> Operand_B[SH_W-1:0];
        else if (in_controlBus[C_ASR])  alu_res = $signed(Operand_A) >>> Operand_B[SH_W-1:0];
        else if (in_controlBus[C_OR])   alu_res = Operand_A | Operand_B;
        else if (in_controlBus[C_AND])  alu_res = Operand_A & Operand_B;
        else if (in_controlBus[C_NOT])  alu_res = ~Operand_B;
        else if (in_controlBus[C_MOV])  alu_res = Operand_B;
    end

    // Branch resolution against the committed flags.
    always_comb begin
        isBranchTaken = 1'b0;
        branchPC      = in_controlBus[C_RET] ? Operand_A : branchTarget;
        if (in_valid && state == S_IDLE) begin
            isBranchTaken = in_controlBus[C_UBR]
                          | (in_controlBus[C_BEQ] & flag_E)
                          | (in_controlBus[C_BGT] & flag_GT);
        end
    end

    // EX/MA latch: single-cycle results from IDLE, divider result from DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_PC         <= '0;
            out_IR         <= '0;
            aluResult      <= '0;
            out_Operand_2  <= '0;
            out_controlBus <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && !is_divmod) begin
                        out_valid      <= 1'b1;
                        out_PC         <= in_PC;
                        out_IR         <= in_IR;
                        aluResult      <= alu_res;
                        out_Operand_2  <= Operand_2;
                        out_controlBus <= in_controlBus;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                S_DONE: begin
                    out_valid      <= 1'b1;
                    out_PC         <= cap_pc;
                    out_IR         <= cap_ir;
                    aluResult      <= div_res;
                    out_Operand_2  <= cap_op2;
                    out_controlBus <= cap_ctrl;
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

    // Flag register, written only by cmp.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_E  <= 1'b0;
            flag_GT <= 1'b0;
        end else if (state == S_IDLE && in_valid && in_controlBus[C_CMP]) begin
            flag_E  <= (Operand_A == Operand_B);
            flag_GT <= ($signed(Operand_A) > $signed(Operand_B));
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage with hand-computed expected values.
module tb_ex_stage;

    localparam int C_ST = 0, C_LD = 1, C_BEQ = 2, C_BGT = 3, C_RET = 4, C_UBR = 7;
    localparam int C_CALL = 8, C_ADD = 9, C_CMP = 11, C_DIV = 13, C_MOD = 14;
    localparam int C_NOT = 20, C_MOV = 21;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_PC, in_IR, Operand_A, Operand_B, Operand_2, branchTarget;
    logic [21:0] in_controlBus;
    logic        ex_stall, isBranchTaken, out_valid, flag_E, flag_GT;
    logic [31:0] branchPC, out_PC, out_IR, aluResult, out_Operand_2;
    logic [21:0] out_controlBus;

    int n_tests = 0;
    int n_fail  = 0;

    ex_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_PC(in_PC), .in_IR(in_IR),
        .in_controlBus(in_controlBus), .Operand_A(Operand_A), .Operand_B(Operand_B),
        .Operand_2(Operand_2), .branchTarget(branchTarget), .ex_stall(ex_stall),
        .isBranchTaken(isBranchTaken), .branchPC(branchPC), .out_valid(out_valid),
        .out_PC(out_PC), .out_IR(out_IR), .aluResult(aluResult),
        .out_Operand_2(out_Operand_2), .out_controlBus(out_controlBus),
        .flag_E(flag_E), .flag_GT(flag_GT)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] cb(input int k);
        return 22'(1) << k;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [21:0] c,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] o2, input logic [31:0] bt);
        in_valid      = v;
        in_PC         = pc;
        in_IR         = pc ^ 32'hA5A5_0000;
        in_controlBus = c;
        Operand_A     = a;
        Operand_B     = b;
        Operand_2     = o2;
        branchTarget  = bt;
        #1;
    endtask

    // Issue a div/mod, measure stall length, then check the latched result.
    task automatic run_div(input string tag, input logic [21:0] c,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        int n;
        n = 0;
        drive(1'b1, 32'h300, c, a, b, 32'h0, 32'h0);
        while (ex_stall && n < 100) begin
            n++;
            tick();
        end
        check({tag, "_stall_cycles"}, 32'(n), 32'd33);
        check({tag, "_done_valid"}, {31'b0, out_valid}, 32'd0);
        tick();
        drive(1'b0, 32'h0, 22'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check(tag, aluResult, exp);
        check({tag, "_pc"}, out_PC, 32'h300);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 22'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_alu", aluResult, 32'd0);
        check("rst_flags", {30'b0, flag_E, flag_GT}, 32'd0);
        check("rst_stall", {31'b0, ex_stall}, 32'd0);

        // Single-cycle ALU ops.
        drive(1'b1, 32'h10, cb(C_ADD), 32'd5, 32'd7, 32'h0, 32'h0);
        tick();
        check("add", aluResult, 32'd12);
        check("add_valid", {31'b0, out_valid}, 32'd1);
        check("add_pc", out_PC, 32'h10);
        check("add_ctrl", {10'b0, out_controlBus}, {10'b0, cb(C_ADD)});
        drive(1'b1, 32'h14, cb(C_MOV), 32'h0, 32'hDEAD, 32'h0, 32'h0);
        tick();
        check("mov", aluResult, 32'h0000_DEAD);
        drive(1'b1, 32'h18, cb(C_NOT), 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        check("not", aluResult, 32'hFFFF_FFFF);
        drive(1'b1, 32'h1C, cb(C_LD), 32'h1000, 32'd8, 32'h0, 32'h0);
        tick();
        check("ld_addr", aluResult, 32'h1008);
        drive(1'b1, 32'h20, cb(C_ST), 32'h20, 32'd4, 32'hCAFE, 32'h0);
        tick();
        check("st_addr", aluResult, 32'h24);
        check("st_data", out_Operand_2, 32'hCAFE);

        // Signed compare: 5 > -1 sets GT.
        drive(1'b1, 32'h24, cb(C_CMP), 32'd5, 32'hFFFF_FFFF, 32'h0, 32'h0);
        tick();
        check("cmp_pos_gt", {30'b0, flag_E, flag_GT}, 32'd1);
        check("cmp_alu", aluResult, 32'd0);
        drive(1'b1, 32'h28, cb(C_BGT), 32'h0, 32'h0, 32'h0, 32'h80);
        check("bgt_taken", {31'b0, isBranchTaken}, 32'd1);
        check("bgt_pc", branchPC, 32'h80);
        tick();

        // cmp -3,2 clears both flags; bgt/beq fall through.
        drive(1'b1, 32'h2C, cb(C_CMP), 32'hFFFF_FFFD, 32'd2, 32'h0, 32'h0);
        tick();
        check("cmp_neg", {30'b0, flag_E, flag_GT}, 32'd0);
        drive(1'b1, 32'h30, cb(C_BGT), 32'h0, 32'h0, 32'h0, 32'h80);
        check("bgt_not_taken", {31'b0, isBranchTaken}, 32'd0);
        tick();
        check("bgt_enters_exma", {31'b0, out_valid}, 32'd1);
        drive(1'b1, 32'h34, cb(C_BEQ), 32'h0, 32'h0, 32'h0, 32'h80);
        check("beq_not_taken", {31'b0, isBranchTaken}, 32'd0);
        tick();

        // cmp 4,4 then beq to 0x40.
        drive(1'b1, 32'h38, cb(C_CMP), 32'd4, 32'd4, 32'h0, 32'h0);
        tick();
        check("cmp_eq", {30'b0, flag_E, flag_GT}, 32'd2);
        drive(1'b1, 32'h3C, cb(C_BEQ), 32'h0, 32'h0, 32'h0, 32'h40);
        check("beq_taken", {31'b0, isBranchTaken}, 32'd1);
        check("beq_pc", branchPC, 32'h40);
        tick();

        // ret and call.
        drive(1'b1, 32'h44, cb(C_RET) | cb(C_UBR), 32'h1234, 32'h0, 32'h0, 32'h999);
        check("ret_taken", {31'b0, isBranchTaken}, 32'd1);
        check("ret_pc", branchPC, 32'h1234);
        tick();
        drive(1'b1, 32'h100, cb(C_CALL) | cb(C_UBR), 32'h0, 32'h0, 32'h0, 32'h200);
        check("call_taken", {31'b0, isBranchTaken}, 32'd1);
        check("call_pc", branchPC, 32'h200);
        tick();
        check("call_link", aluResult, 32'h104);

        // Divider.
        run_div("div_m7_2", cb(C_DIV), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_div("mod_m7_2", cb(C_MOD), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_div("div_9_0", cb(C_DIV), 32'd9, 32'd0, 32'hFFFF_FFFF);
        run_div("mod_9_0", cb(C_MOD), 32'd9, 32'd0, 32'd9);
        run_div("div_ovf", cb(C_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_div("mod_ovf", cb(C_MOD), 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_div("div_100_m7", cb(C_DIV), 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);
        run_div("mod_100_m7", cb(C_MOD), 32'd100, 32'hFFFF_FFF9, 32'd2);
        check("div_no_flags", {30'b0, flag_E, flag_GT}, 32'd2);

        // Reset in the middle of a divide.
        drive(1'b1, 32'h400, cb(C_DIV), 32'd1000, 32'd3, 32'h0, 32'h0);
        repeat (10) tick();
        check("mid_div_stall", {31'b0, ex_stall}, 32'd1);
        reset = 1'b1;
        drive(1'b0, 32'h0, 22'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        reset = 1'b0;
        check("abort_valid", {31'b0, out_valid}, 32'd0);
        check("abort_alu", aluResult, 32'd0);
        check("abort_pc", out_PC, 32'd0);
        check("abort_ctrl", {10'b0, out_controlBus}, 32'd0);
        check("abort_flags", {30'b0, flag_E, flag_GT}, 32'd0);
        check("abort_stall", {31'b0, ex_stall}, 32'd0);
        drive(1'b1, 32'h500, cb(C_ADD), 32'd1, 32'd1, 32'h0, 32'h0);
        tick();
        check("post_abort_add", aluResult, 32'd2);
        check("post_abort_valid", {31'b0, out_valid}, 32'd1);

        // Bubbles between two adds; a non-valid cmp must not touch flags.
        drive(1'b1, 32'h504, cb(C_CMP), 32'd6, 32'd6, 32'h0, 32'h0);
        tick();
        drive(1'b1, 32'h508, cb(C_ADD), 32'd1, 32'd2, 32'h0, 32'h0);
        tick();
        check("bub_v0", {31'b0, out_valid}, 32'd1);
        drive(1'b0, 32'h50C, cb(C_CMP), 32'd9, 32'd1, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bub_gap_valid", {31'b0, out_valid}, 32'd0);
            check("bub_gap_hold", aluResult, 32'd3);
        end
        drive(1'b1, 32'h510, cb(C_ADD), 32'd3, 32'd4, 32'h0, 32'h0);
        tick();
        check("bub_v4", {31'b0, out_valid}, 32'd1);
        check("bub_add", aluResult, 32'd7);
        check("bub_flags", {30'b0, flag_E, flag_GT}, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
